// File: rtl/ex_fp_unit_if.sv
`default_nettype none
// ============================================================================
// ex_fp_unit_if
// ----------------------------------------------------------------------------
// Bundles the ID/EX-side request (start, op, operands, destination tag) and
// the FP unit's response (result, tag, valid pulse, busy, pipeline stall).
//   master : the ID/EX / control side driving requests
//   slave  : the FP unit
// Revision: 1.0 - initial release
// ============================================================================
interface ex_fp_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              start;
  logic [1:0]        op;
  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] operand_b;
  logic [ADDR_W-1:0] dest_in;
  logic [DATA_W-1:0] result;
  logic [ADDR_W-1:0] dest_out;
  logic              valid;
  logic              busy;
  logic              stall;

  modport master (
    output start, op, operand_a, operand_b, dest_in,
    input  result, dest_out, valid, busy, stall
  );

  modport slave (
    input  start, op, operand_a, operand_b, dest_in,
    output result, dest_out, valid, busy, stall
  );
endinterface
`default_nettype wire

// File: rtl/ex_fp_unit.sv
`default_nettype none
// ============================================================================
// ex_fp_unit
// ----------------------------------------------------------------------------
// Multi-cycle IEEE-754 single-precision add / sub / mul unit for the EX stage.
// Fixed six-state sequence IDLE->UNPACK->ALIGN->EXEC->NORM->DONE, truncation
// rounding, denormal inputs flushed to zero, NaN/Inf inputs give NAN_CODE.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high
//   bus    : ex_fp_unit_if.slave
//            start/op/operand_a/operand_b/dest_in in,
//            result/dest_out/valid/busy/stall out
// Revision: 1.0 - initial release
// ============================================================================
module ex_fp_unit #(
  parameter int          DATA_W   = 32,
  parameter int          ADDR_W   = 5,
  parameter logic [31:0] NAN_CODE = 32'h7FC0_0000
) (
  input  wire           clk,
  input  wire           reset,
  ex_fp_unit_if.slave   bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_UNPACK = 3'd1;
  localparam logic [2:0] S_ALIGN  = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_NORM   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0] state;
  logic [2:0] state_nxt;

  // captured request
  logic [1:0]        op_q;
  logic [31:0]       a_q;
  logic [31:0]       b_q;
  logic [ADDR_W-1:0] dest_q;

  // unpacked fields
  logic        sa_q, sb_q;
  logic [7:0]  ea_q, eb_q;
  logic [23:0] ma_q, mb_q;
  logic        nan_q, za_q, zb_q;

  // aligned add/sub operands (24-bit mantissa + 3 guard bits)
  logic [26:0] big_m_q, small_m_q;
  logic [7:0]  e_big_q;
  logic        s_big_q, s_small_q;

  // raw execute result: value whose hidden-bit position is bit 46 for e_q
  logic [47:0]       v_q;
  logic signed [9:0] e_q;
  logic              s_q;

  logic [DATA_W-1:0] result_q;
  logic [ADDR_W-1:0] dest_out_q;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus.start) state_nxt = S_UNPACK;
      S_UNPACK: state_nxt = S_ALIGN;
      S_ALIGN:  state_nxt = S_EXEC;
      S_EXEC:   state_nxt = S_NORM;
      S_NORM:   state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs. Stall drops in DONE so ID/EX can load the next op on the
  // DONE->IDLE edge.
  always_comb begin
    bus.busy  = (state != S_IDLE);
    bus.valid = (state == S_DONE);
    bus.stall = ((state == S_IDLE) && bus.start) ||
                (state == S_UNPACK) || (state == S_ALIGN) ||
                (state == S_EXEC)   || (state == S_NORM);
  end

  // --------------------------------------------------------------------------
  // ALIGN combinational: order by magnitude, shift the smaller mantissa
  // --------------------------------------------------------------------------
  logic        a_ge_b;
  logic [7:0]  e_diff;
  logic [26:0] small_ext;
  logic [26:0] small_aligned;

  always_comb begin
    a_ge_b    = {ea_q, ma_q} >= {eb_q, mb_q};
    e_diff    = a_ge_b ? (ea_q - eb_q) : (eb_q - ea_q);
    small_ext = a_ge_b ? {mb_q, 3'b000} : {ma_q, 3'b000};
    small_aligned = (e_diff >= 8'd26) ? 27'd0 : (small_ext >> e_diff);
  end

  // --------------------------------------------------------------------------
  // EXEC combinational
  // --------------------------------------------------------------------------
  logic [27:0]       addsub;
  logic [47:0]       prod;
  logic signed [9:0] mul_exp;

  always_comb begin
    if (s_big_q == s_small_q) addsub = {1'b0, big_m_q} + {1'b0, small_m_q};
    else                      addsub = {1'b0, big_m_q} - {1'b0, small_m_q};
    prod    = 48'(ma_q) * 48'(mb_q);
    mul_exp = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - 10'sd127;
  end

  // --------------------------------------------------------------------------
  // NORM combinational: leading-zero count, one shift, exponent fix-up and
  // special-case packing. After the shift the MSB sits at bit 47, so the
  // exponent gains one relative to the bit-46 reference and loses lz.
  // --------------------------------------------------------------------------
  logic [5:0]        lz;
  logic [47:0]       shifted;
  logic [22:0]       mant;
  logic signed [9:0] e_norm;
  logic [31:0]       packed_res;

  always_comb begin
    lz = 6'd0;
    for (int i = 0; i < 48; i++) begin
      if (v_q[i]) lz = 6'(47 - i);
    end
    shifted = v_q << lz;
    mant    = 23'(shifted >> 24);
    e_norm  = e_q + 10'sd1 - $signed({4'b0000, lz});

    if (nan_q)
      packed_res = NAN_CODE;
    else if (op_q == 2'b11)
      packed_res = 32'h0;
    else if ((op_q == 2'b10) && (za_q || zb_q))
      packed_res = {sa_q ^ sb_q, 31'h0};
    else if (!op_q[1] && (v_q == 48'd0))
      packed_res = 32'h0;
    else if (e_norm >= 10'sd255)
      packed_res = {s_q, 8'hFF, 23'h0};
    else if (e_norm <= 10'sd0)
      packed_res = {s_q, 31'h0};
    else
      packed_res = {s_q, e_norm[7:0], mant};
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= 2'b00;
      a_q        <= 32'h0;
      b_q        <= 32'h0;
      dest_q     <= '0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      ea_q       <= 8'h0;
      eb_q       <= 8'h0;
      ma_q       <= 24'h0;
      mb_q       <= 24'h0;
      nan_q      <= 1'b0;
      za_q       <= 1'b0;
      zb_q       <= 1'b0;
      big_m_q    <= 27'h0;
      small_m_q  <= 27'h0;
      e_big_q    <= 8'h0;
      s_big_q    <= 1'b0;
      s_small_q  <= 1'b0;
      v_q        <= 48'h0;
      e_q        <= 10'sd0;
      s_q        <= 1'b0;
      result_q   <= '0;
      dest_out_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            op_q   <= bus.op;
            a_q    <= bus.operand_a;
            b_q    <= bus.operand_b;
            dest_q <= bus.dest_in;
          end
        end
        S_UNPACK: begin
          sa_q  <= a_q[31];
          // subtraction is addition of the negated second operand
          sb_q  <= b_q[31] ^ (op_q == 2'b01);
          ea_q  <= a_q[30:23];
          eb_q  <= b_q[30:23];
          // zero exponent flushes the operand to a (signed) zero
          ma_q  <= (a_q[30:23] != 8'h0) ? {1'b1, a_q[22:0]} : 24'h0;
          mb_q  <= (b_q[30:23] != 8'h0) ? {1'b1, b_q[22:0]} : 24'h0;
          nan_q <= (a_q[30:23] == 8'hFF) || (b_q[30:23] == 8'hFF);
          za_q  <= (a_q[30:23] == 8'h0);
          zb_q  <= (b_q[30:23] == 8'h0);
        end
        S_ALIGN: begin
          big_m_q   <= a_ge_b ? {ma_q, 3'b000} : {mb_q, 3'b000};
          small_m_q <= small_aligned;
          e_big_q   <= a_ge_b ? ea_q : eb_q;
          s_big_q   <= a_ge_b ? sa_q : sb_q;
          s_small_q <= a_ge_b ? sb_q : sa_q;
        end
        S_EXEC: begin
          if (op_q[1]) begin
            v_q <= prod;
            e_q <= mul_exp;
            s_q <= sa_q ^ sb_q;
          end else begin
            // 27-bit hidden bit (26) moved to the common bit-46 reference
            v_q <= {addsub, 20'h0};
            e_q <= $signed({2'b00, e_big_q});
            s_q <= s_big_q;
          end
        end
        S_NORM: begin
          result_q   <= packed_res;
          dest_out_q <= dest_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.result   = result_q;
  assign bus.dest_out = dest_out_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_fp_unit.sv
`default_nettype none
// ============================================================================
// tb_ex_fp_unit
// ----------------------------------------------------------------------------
// Directed self-checking bench for ex_fp_unit. Inputs change and outputs are
// sampled on the falling clock edge.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ex_fp_unit;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  ex_fp_unit_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  ex_fp_unit #(.DATA_W(32), .ADDR_W(5), .NAN_CODE(32'h7FC0_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one op for a single cycle, then waits for valid.
  // lat counts rising edges from the capturing edge (1) to the edge entering
  // DONE; stalls counts sampled cycles with stall high. Returns in DONE.
  task automatic launch(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] d,
                        output int lat, output int stalls);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.operand_a = a; bus.operand_b = b;
    bus.dest_in = d;
    #1;
    stalls = bus.stall ? 1 : 0;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.valid && lat < 20) begin
      if (bus.stall) stalls++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.operand_a = '0; bus.operand_b = '0;
    bus.dest_in = '0;
    repeat (3) @(negedge clk);
    total++; if (bus.result !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want 00000000", bus.result); end
    total++; if (bus.dest_out !== 5'd0) begin bad++; $display("FAIL reset_dest: got %0d want 0", bus.dest_out); end
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_no_start_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_arith();
    logic [1:0]  vop [11];
    logic [31:0] va  [11];
    logic [31:0] vb  [11];
    logic [31:0] vr  [11];
    int lat, stalls;
    vop[0]  = 2'b00; va[0]  = 32'h3FC00000; vb[0]  = 32'h40200000; vr[0]  = 32'h40800000; // 1.5+2.5
    vop[1]  = 2'b01; va[1]  = 32'h40400000; vb[1]  = 32'h40400000; vr[1]  = 32'h00000000; // 3-3
    vop[2]  = 2'b01; va[2]  = 32'h3F800000; vb[2]  = 32'h40000000; vr[2]  = 32'hBF800000; // 1-2
    vop[3]  = 2'b10; va[3]  = 32'h40000000; vb[3]  = 32'h40400000; vr[3]  = 32'h40C00000; // 2*3
    vop[4]  = 2'b10; va[4]  = 32'hC0000000; vb[4]  = 32'h00000000; vr[4]  = 32'h80000000; // -2*0
    vop[5]  = 2'b10; va[5]  = 32'h7F000000; vb[5]  = 32'h40000000; vr[5]  = 32'h7F800000; // overflow
    vop[6]  = 2'b00; va[6]  = 32'h7F800000; vb[6]  = 32'h3F800000; vr[6]  = 32'h7FC00000; // Inf in
    vop[7]  = 2'b11; va[7]  = 32'h3F800000; vb[7]  = 32'h3F800000; vr[7]  = 32'h00000000; // reserved
    vop[8]  = 2'b00; va[8]  = 32'h00000001; vb[8]  = 32'h3F800000; vr[8]  = 32'h3F800000; // FTZ
    vop[9]  = 2'b10; va[9]  = 32'h00800000; vb[9]  = 32'h00800000; vr[9]  = 32'h00000000; // underflow
    vop[10] = 2'b00; va[10] = 32'h3F800000; vb[10] = 32'hBF800000; vr[10] = 32'h00000000; // 1+(-1)
    for (int i = 0; i < 11; i++) begin
      launch(vop[i], va[i], vb[i], 5'(i + 3), lat, stalls);
      total++; if (lat !== 5) begin bad++; $display("FAIL arith_latency[%0d]: got %0d want 5", i, lat); end
      total++; if (stalls !== 5) begin bad++; $display("FAIL arith_stall_cycles[%0d]: got %0d want 5", i, stalls); end
      total++; if (bus.result !== vr[i]) begin bad++; $display("FAIL arith_result[%0d]: got %h want %h", i, bus.result, vr[i]); end
      total++; if (bus.dest_out !== 5'(i + 3)) begin bad++; $display("FAIL arith_dest[%0d]: got %0d want %0d", i, bus.dest_out, i + 3); end
      total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL arith_done_stall[%0d]: got %b want 0", i, bus.stall); end
      @(negedge clk);
      total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL arith_valid_pulse[%0d]: got %b want 0", i, bus.valid); end
      total++; if (bus.result !== vr[i]) begin bad++; $display("FAIL arith_result_hold[%0d]: got %h want %h", i, bus.result, vr[i]); end
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.operand_a = 32'h3FC00000;
    bus.operand_b = 32'h40200000; bus.dest_in = 5'd21;
    @(negedge clk);                    // UNPACK
    bus.start = 1'b0;
    @(negedge clk);                    // ALIGN: re-pulse with a different op
    bus.start = 1'b1; bus.op = 2'b10; bus.operand_a = 32'h40000000;
    bus.operand_b = 32'h40400000; bus.dest_in = 5'd9;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 3;
    while (!bus.valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    total++; if (lat !== 5) begin bad++; $display("FAIL ignore_latency: got %0d want 5", lat); end
    total++; if (bus.result !== 32'h40800000) begin bad++; $display("FAIL ignore_result: got %h want 40800000", bus.result); end
    total++; if (bus.dest_out !== 5'd21) begin bad++; $display("FAIL ignore_dest: got %0d want 21", bus.dest_out); end
    repeat (3) @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ignore_no_requeue: busy got %b want 0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    int lat, stalls;
    launch(2'b10, 32'h40000000, 32'h40400000, 5'd13, lat, stalls);
    total++; if (bus.result !== 32'h40C00000) begin bad++; $display("FAIL b2b_first_result: got %h want 40C00000", bus.result); end
    total++; if (bus.dest_out !== 5'd13) begin bad++; $display("FAIL b2b_first_dest: got %0d want 13", bus.dest_out); end
    // next op arrives in the IDLE cycle right after DONE
    launch(2'b01, 32'h3F800000, 32'h40000000, 5'd14, lat, stalls);
    total++; if (lat !== 5) begin bad++; $display("FAIL b2b_second_latency: got %0d want 5", lat); end
    total++; if (bus.result !== 32'hBF800000) begin bad++; $display("FAIL b2b_second_result: got %h want BF800000", bus.result); end
    total++; if (bus.dest_out !== 5'd14) begin bad++; $display("FAIL b2b_second_dest: got %0d want 14", bus.dest_out); end
  endtask

  task automatic test_reset_mid_op();
    int seen;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.operand_a = 32'h3FC00000;
    bus.operand_b = 32'h40200000; bus.dest_in = 5'd30;
    @(negedge clk);                    // UNPACK
    bus.start = 1'b0;
    @(negedge clk);                    // ALIGN
    @(negedge clk);                    // EXEC
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before: got %b want 1", bus.busy); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL midrst_stall: got %b want 0", bus.stall); end
    total++; if (bus.result !== 32'h0) begin bad++; $display("FAIL midrst_result: got %h want 00000000", bus.result); end
    seen = 0;
    repeat (8) begin
      if (bus.valid) seen++;
      @(negedge clk);
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL midrst_valid_pulses: got %0d want 0", seen); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_arith();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
